// File: rtl/wb_regfile_sb.sv
// Write-back stage and register file with a per-register pending-write scoreboard.
// The scoreboard stalls issue on read-after-write hazards; there is no forwarding network.
module wb_regfile_sb #(
  parameter int unsigned           CODE_SIZE = 6,
  parameter int unsigned           REG_SIZE  = 5,
  parameter int unsigned           DATA_SIZE = 32,
  parameter int unsigned           CNT_SIZE  = 3,
  parameter logic [CODE_SIZE-1:0]  OP_LW     = 6'd35,
  parameter logic [CODE_SIZE-1:0]  OP_SW     = 6'd43,
  parameter logic [CODE_SIZE-1:0]  OP_BEQ    = 6'd4,
  parameter logic [CODE_SIZE-1:0]  OP_BNE    = 6'd5,
  parameter logic [CODE_SIZE-1:0]  OP_J      = 6'd2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [CODE_SIZE-1:0] iss_icode,
  input  logic [REG_SIZE-1:0]  iss_ri,
  input  logic [REG_SIZE-1:0]  iss_rj,
  input  logic [REG_SIZE-1:0]  iss_rk,
  output logic [DATA_SIZE-1:0] jout,
  output logic [DATA_SIZE-1:0] kout,
  output logic                 stall,
  input  logic [REG_SIZE-1:0]  wb_ri,
  input  logic [CODE_SIZE-1:0] wb_icode,
  input  logic [DATA_SIZE-1:0] wb_mout,
  input  logic [DATA_SIZE-1:0] wb_aout,
  output logic                 sb_err
);

  localparam int unsigned          NREG    = 2**REG_SIZE;
  localparam logic [CNT_SIZE-1:0]  CNT_MAX = '1;
  localparam logic [CNT_SIZE-1:0]  CNT_ONE = CNT_SIZE'(1);

  function automatic logic f_writes(input logic [CODE_SIZE-1:0] op,
                                    input logic [REG_SIZE-1:0]  r);
    return (op != '0) && (op != OP_SW) && (op != OP_BEQ) &&
           (op != OP_BNE) && (op != OP_J) && (r != '0);
  endfunction

  logic [DATA_SIZE-1:0] r_regs [NREG];
  logic [CNT_SIZE-1:0]  r_pend [NREG];
  logic                 r_sb_err;

  logic                 w_wb_wr;
  logic [DATA_SIZE-1:0] w_wb_data;
  logic                 w_iss_wr;
  logic                 w_hz_j;
  logic                 w_hz_k;
  logic [NREG-1:0]      w_inc_vec;
  logic [NREG-1:0]      w_dec_vec;
  logic [CNT_SIZE-1:0]  w_pend_nxt [NREG];
  logic                 w_err;

  assign w_wb_wr   = f_writes(wb_icode, wb_ri);
  assign w_wb_data = (wb_icode == OP_LW) ? wb_mout : wb_aout;

  // A source is clear if it has nothing pending, or its last pending write commits this cycle
  always_comb begin
    w_hz_j = 1'b0;
    w_hz_k = 1'b0;
    if (iss_rj != '0 && r_pend[iss_rj] != '0)
      w_hz_j = !(r_pend[iss_rj] == CNT_ONE && w_wb_wr && wb_ri == iss_rj);
    if (iss_rk != '0 && r_pend[iss_rk] != '0)
      w_hz_k = !(r_pend[iss_rk] == CNT_ONE && w_wb_wr && wb_ri == iss_rk);
  end

  assign stall    = iss_valid && (w_hz_j || w_hz_k);
  assign w_iss_wr = iss_valid && !stall && f_writes(iss_icode, iss_ri);

  // Source reads with write-through from the committing instruction
  always_comb begin
    jout = '0;
    kout = '0;
    if (iss_rj != '0)
      jout = (w_wb_wr && wb_ri == iss_rj) ? w_wb_data : r_regs[iss_rj];
    if (iss_rk != '0)
      kout = (w_wb_wr && wb_ri == iss_rk) ? w_wb_data : r_regs[iss_rk];
  end

  assign w_inc_vec = w_iss_wr ? (NREG'(1) << iss_ri) : '0;
  assign w_dec_vec = w_wb_wr  ? (NREG'(1) << wb_ri)  : '0;

  // Counter update; overflow and underflow saturate and flag the error
  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_pend_nxt[i] = r_pend[i];
      if (i != 0) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          if (r_pend[i] == CNT_MAX) w_err = 1'b1;
          else                      w_pend_nxt[i] = r_pend[i] + CNT_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
          if (r_pend[i] == '0) w_err = 1'b1;
          else                 w_pend_nxt[i] = r_pend[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      if (w_wb_wr) r_regs[wb_ri] <= w_wb_data;
      for (int i = 1; i < NREG; i++) r_pend[i] <= w_pend_nxt[i];
      if (w_err) r_sb_err <= 1'b1;
    end
  end

  assign sb_err = r_sb_err;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Directed bench for wb_regfile_sb: reset, write-back, bypass, RAW stall, WAW, counter errors.
module tb_wb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [5:0]  iss_icode;
  logic [4:0]  iss_ri, iss_rj, iss_rk;
  logic [31:0] jout, kout;
  logic        stall;
  logic [4:0]  wb_ri;
  logic [5:0]  wb_icode;
  logic [31:0] wb_mout, wb_aout;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_LW  = 6'd35;

  always #5 clk = ~clk;

  wb_regfile_sb dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_icode(iss_icode),
    .iss_ri(iss_ri), .iss_rj(iss_rj), .iss_rk(iss_rk),
    .jout(jout), .kout(kout), .stall(stall),
    .wb_ri(wb_ri), .wb_icode(wb_icode), .wb_mout(wb_mout), .wb_aout(wb_aout),
    .sb_err(sb_err)
  );

  // Move to the next negedge with all inputs quiet
  task automatic idle();
    @(negedge clk);
    rst = 1'b0; iss_valid = 1'b0; iss_icode = '0;
    iss_ri = '0; iss_rj = '0; iss_rk = '0;
    wb_ri = '0; wb_icode = '0; wb_mout = '0; wb_aout = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    wb_icode = 6'h08; wb_ri = 5'd3; wb_aout = 32'h5;
    iss_valid = 1'b1; iss_icode = 6'h08; iss_ri = 5'd3;
    idle();
    iss_valid = 1'b1; iss_rj = 5'd3; iss_rk = 5'd3;
    #1;
    checks++; if (jout !== 32'h0) begin errors++; $display("FAIL reset_jout got %h want 0", jout); end
    checks++; if (kout !== 32'h0) begin errors++; $display("FAIL reset_kout got %h want 0", kout); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err got %b want 0", sb_err); end
  endtask

  task automatic test_writeback();
    idle();
    iss_valid = 1'b1; iss_icode = 6'h08; iss_ri = 5'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_issue_stall got %b want 0", stall); end
    idle();
    wb_icode = 6'h08; wb_ri = 5'd3; wb_aout = 32'hDEAD_BEEF; wb_mout = 32'h1111;
    idle();
    iss_rj = 5'd3;
    #1;
    checks++; if (jout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_aout_read got %h want deadbeef", jout); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL wb_sb_err got %b want 0", sb_err); end
  endtask

  task automatic test_bypass();
    idle();
    iss_valid = 1'b1; iss_icode = OP_LW; iss_ri = 5'd7;
    idle();
    wb_icode = OP_LW; wb_ri = 5'd7; wb_mout = 32'h1234; wb_aout = 32'h9;
    iss_valid = 1'b1; iss_icode = 6'd0; iss_rj = 5'd7; iss_rk = 5'd7;
    #1;
    checks++; if (kout !== 32'h1234) begin errors++; $display("FAIL bypass_kout got %h want 1234", kout); end
    checks++; if (jout !== 32'h1234) begin errors++; $display("FAIL bypass_jout got %h want 1234", jout); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bypass_stall got %b want 0", stall); end
    idle();
    iss_rk = 5'd7;
    #1;
    checks++; if (kout !== 32'h1234) begin errors++; $display("FAIL lw_array_kout got %h want 1234", kout); end
  endtask

  task automatic test_stall();
    logic [4:0] exp_stall [3];
    exp_stall = '{5'd1, 5'd1, 5'd0};
    idle();
    iss_valid = 1'b1; iss_icode = OP_ADD; iss_ri = 5'd5;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got %b want 0", stall); end
    for (int c = 0; c < 3; c++) begin
      idle();
      iss_valid = 1'b1; iss_icode = OP_ADD; iss_ri = 5'd1; iss_rj = 5'd5;
      if (c == 2) begin wb_icode = OP_ADD; wb_ri = 5'd5; wb_aout = 32'h55; end
      #1;
      checks++;
      if (stall !== exp_stall[c][0]) begin
        errors++; $display("FAIL raw_stall_c%0d got %b want %b", c, stall, exp_stall[c][0]);
      end
    end
    checks++; if (jout !== 32'h55) begin errors++; $display("FAIL raw_bypass_jout got %h want 55", jout); end
    idle();
    wb_icode = OP_ADD; wb_ri = 5'd1; wb_aout = 32'h11;
    idle();
    iss_valid = 1'b1; iss_rj = 5'd1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stalled_not_counted got %b want 0", stall); end
    checks++; if (jout !== 32'h11) begin errors++; $display("FAIL r1_read got %h want 11", jout); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL raw_sb_err got %b want 0", sb_err); end
  endtask

  task automatic test_waw();
    for (int c = 0; c < 2; c++) begin
      idle();
      iss_valid = 1'b1; iss_icode = OP_ADD; iss_ri = 5'd6;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_issue%0d got %b want 0", c, stall); end
    end
    idle();
    iss_valid = 1'b1; iss_rk = 5'd6;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_pend2 got %b want 1", stall); end
    idle();
    iss_valid = 1'b1; iss_rk = 5'd6;
    wb_icode = OP_ADD; wb_ri = 5'd6; wb_aout = 32'h66;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_pend2_dec got %b want 1", stall); end
    idle();
    iss_valid = 1'b1; iss_rk = 5'd6;
    wb_icode = OP_ADD; wb_ri = 5'd6; wb_aout = 32'h67;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_pend1_dec got %b want 0", stall); end
    checks++; if (kout !== 32'h67) begin errors++; $display("FAIL waw_bypass got %h want 67", kout); end
    idle();
    iss_valid = 1'b1; iss_rk = 5'd6;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL waw_drained got %b want 0", stall); end
    checks++; if (kout !== 32'h67) begin errors++; $display("FAIL waw_final got %h want 67", kout); end
  endtask

  task automatic test_no_write();
    logic [5:0] ops [5];
    ops = '{6'd43, 6'd4, 6'd5, 6'd2, 6'd0};
    for (int c = 0; c < 5; c++) begin
      idle();
      iss_valid = 1'b1; iss_icode = ops[c]; iss_ri = 5'd4;
    end
    idle();
    iss_valid = 1'b1; iss_rj = 5'd4; iss_rk = 5'd4;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nowrite_stall got %b want 0", stall); end
  endtask

  task automatic test_reg0();
    idle();
    wb_icode = OP_ADD; wb_ri = 5'd0; wb_aout = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rj = 5'd0; iss_rk = 5'd0;
    #1;
    checks++; if (jout !== 32'h0) begin errors++; $display("FAIL reg0_bypass got %h want 0", jout); end
    idle();
    iss_rj = 5'd0;
    #1;
    checks++; if (jout !== 32'h0) begin errors++; $display("FAIL reg0_array got %h want 0", jout); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reg0_sb_err got %b want 0", sb_err); end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 7) begin
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL ovf_at_max got %b want 0", sb_err); end
      end
      iss_valid = 1'b1; iss_icode = OP_ADD; iss_ri = 5'd10;
    end
    idle();
    iss_valid = 1'b1; iss_rj = 5'd10;
    #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL ovf_sb_err got %b want 1", sb_err); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ovf_stall got %b want 1", stall); end
  endtask

  task automatic test_reset_midflight();
    idle();
    rst = 1'b1;
    idle();
    iss_valid = 1'b1; iss_icode = OP_ADD; iss_ri = 5'd9;
    idle();
    rst = 1'b1;
    idle();
    iss_valid = 1'b1; iss_rj = 5'd9; iss_rk = 5'd10;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    checks++; if (jout !== 32'h0) begin errors++; $display("FAIL flush_r9 got %h want 0", jout); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL flush_sb_err got %b want 0", sb_err); end
    idle();
    wb_icode = OP_ADD; wb_ri = 5'd9; wb_aout = 32'h77;
    idle();
    iss_rj = 5'd9;
    #1;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL underflow_sb_err got %b want 1", sb_err); end
    checks++; if (jout !== 32'h77) begin errors++; $display("FAIL underflow_write got %h want 77", jout); end
  endtask

  initial begin
    rst = 1'b1; iss_valid = 1'b0; iss_icode = '0;
    iss_ri = '0; iss_rj = '0; iss_rk = '0;
    wb_ri = '0; wb_icode = '0; wb_mout = '0; wb_aout = '0;
    test_reset();
    test_writeback();
    test_bypass();
    test_stall();
    test_waw();
    test_no_write();
    test_reg0();
    test_overflow();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
